// File: rtl/wordle_guess_checker.sv
// Wordle guess entry and scoring: assembles a 5-letter guess from keyboard codes,
// scores it against a latched target (green pass, then one yellow position per cycle).
module wordle_guess_checker #(
    parameter int MAX_GUESSES = 6
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Ack,
    input  logic [4:0]  key_code,
    input  logic        key_valid,
    input  logic [24:0] target,
    output logic [24:0] guess_out,
    output logic [2:0]  guess_len,
    output logic [9:0]  result,
    output logic        result_valid,
    output logic [2:0]  attempt,
    output logic        win,
    output logic        lose,
    output logic        q_I,
    output logic        q_Entry,
    output logic        q_Green,
    output logic        q_Yellow,
    output logic        q_Report,
    output logic        q_Done
);
    typedef enum logic [2:0] {
        QI      = 3'd0,
        QENTRY  = 3'd1,
        QGREEN  = 3'd2,
        QYELLOW = 3'd3,
        QREPORT = 3'd4,
        QDONE   = 3'd5
    } state_t;

    localparam logic [9:0] ALL_GREEN = 10'b1010101010;

    state_t      state;
    logic [24:0] tgt;
    logic [4:0]  used;
    logic [2:0]  yidx;

    logic [4:0]  g_slot [5];
    logic [4:0]  t_slot [5];
    logic [4:0]  cur;
    logic        hit;
    logic [2:0]  hit_j;

    // Lowest unused target position matching the guess letter under yidx.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            g_slot[i] = guess_out[5*i +: 5];
            t_slot[i] = tgt[5*i +: 5];
        end
        cur   = g_slot[yidx];
        hit   = 1'b0;
        hit_j = 3'd0;
        for (int j = 4; j >= 0; j--) begin
            if (!used[j] && t_slot[j] == cur) begin
                hit   = 1'b1;
                hit_j = 3'(j);
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= QI;
            tgt       <= '0;
            guess_out <= '1;
            guess_len <= '0;
            result    <= '0;
            attempt   <= '0;
            win       <= 1'b0;
            lose      <= 1'b0;
            used      <= '0;
            yidx      <= '0;
        end else begin
            case (state)
                QI: if (Start) begin
                    tgt       <= target;
                    guess_out <= '1;
                    guess_len <= '0;
                    attempt   <= '0;
                    win       <= 1'b0;
                    lose      <= 1'b0;
                    state     <= QENTRY;
                end
                QENTRY: if (key_valid) begin
                    if (key_code < 5'd26) begin
                        if (guess_len < 3'd5) begin
                            for (int i = 0; i < 5; i++)
                                if (3'(i) == guess_len) guess_out[5*i +: 5] <= key_code;
                            guess_len <= guess_len + 3'd1;
                        end
                    end else if (key_code == 5'd26) begin
                        if (guess_len != 3'd0) begin
                            for (int i = 0; i < 5; i++)
                                if (3'(i) == guess_len - 3'd1) guess_out[5*i +: 5] <= 5'h1F;
                            guess_len <= guess_len - 3'd1;
                        end
                    end else if (key_code == 5'd27 && guess_len == 3'd5) begin
                        state <= QGREEN;
                    end
                end
                QGREEN: begin
                    for (int i = 0; i < 5; i++) begin
                        if (g_slot[i] == t_slot[i]) begin
                            result[2*i +: 2] <= 2'b10;
                            used[i]          <= 1'b1;
                        end else begin
                            result[2*i +: 2] <= 2'b00;
                            used[i]          <= 1'b0;
                        end
                    end
                    yidx  <= '0;
                    state <= QYELLOW;
                end
                QYELLOW: begin
                    // A green position already consumed its own target letter.
                    if (!result[{yidx, 1'b1}] && hit) begin
                        result[{yidx, 1'b0} +: 2] <= 2'b01;
                        used[hit_j]               <= 1'b1;
                    end
                    if (yidx == 3'd4) state <= QREPORT;
                    else              yidx  <= yidx + 3'd1;
                end
                QREPORT: begin
                    attempt <= attempt + 3'd1;
                    if (result == ALL_GREEN) begin
                        win   <= 1'b1;
                        state <= QDONE;
                    end else if (attempt + 3'd1 == 3'(MAX_GUESSES)) begin
                        lose  <= 1'b1;
                        state <= QDONE;
                    end else begin
                        guess_out <= '1;
                        guess_len <= '0;
                        state     <= QENTRY;
                    end
                end
                QDONE: if (Ack) state <= QI;
                default: state <= QI;
            endcase
        end
    end

    assign result_valid = (state == QREPORT);
    assign q_I          = (state == QI);
    assign q_Entry      = (state == QENTRY);
    assign q_Green      = (state == QGREEN);
    assign q_Yellow     = (state == QYELLOW);
    assign q_Report     = (state == QREPORT);
    assign q_Done       = (state == QDONE);
endmodule

// File: tb/tb_wordle_guess_checker.sv
// Directed and randomized checks of wordle_guess_checker against a letter-count
// Wordle scoring model.
module tb_wordle_guess_checker;
    logic        Clk = 1'b0;
    logic        reset, Start, Ack, key_valid;
    logic [4:0]  key_code;
    logic [24:0] target;
    logic [24:0] guess_out;
    logic [2:0]  guess_len, attempt;
    logic [9:0]  result;
    logic        result_valid, win, lose;
    logic        q_I, q_Entry, q_Green, q_Yellow, q_Report, q_Done;

    int checks = 0;
    int errors = 0;

    wordle_guess_checker #(.MAX_GUESSES(6)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
        .key_code(key_code), .key_valid(key_valid), .target(target),
        .guess_out(guess_out), .guess_len(guess_len), .result(result),
        .result_valid(result_valid), .attempt(attempt), .win(win), .lose(lose),
        .q_I(q_I), .q_Entry(q_Entry), .q_Green(q_Green), .q_Yellow(q_Yellow),
        .q_Report(q_Report), .q_Done(q_Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] word(input int a, input int b, input int c, input int d, input int e);
        return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Standard Wordle scoring: greens first, then yellows drawn from the
    // remaining per-letter counts of the target, left to right.
    function automatic logic [9:0] score(input logic [24:0] g, input logic [24:0] t);
        int cnt [32];
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        for (int i = 0; i < 5; i++)
            if (g[5*i +: 5] == t[5*i +: 5]) r[2*i +: 2] = 2'b10;
            else cnt[t[5*i +: 5]]++;
        for (int i = 0; i < 5; i++)
            if (r[2*i +: 2] != 2'b10 && cnt[g[5*i +: 5]] > 0) begin
                r[2*i +: 2] = 2'b01;
                cnt[g[5*i +: 5]]--;
            end
        return r;
    endfunction

    task automatic press(input logic [4:0] code);
        @(negedge Clk);
        key_code  = code;
        key_valid = 1'b1;
        @(negedge Clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [24:0] t);
        @(negedge Clk);
        target = t;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
    endtask

    // Types a word and enter; returns at the negedge where result_valid is seen.
    // lat counts negedges after the enter edge (6 => 7 cycles from the key cycle).
    task automatic submit(input logic [24:0] w, input bit inject, output int lat);
        for (int i = 0; i < 5; i++) press(w[5*i +: 5]);
        press(5'd27);
        lat = 0;
        while (!result_valid && lat < 20) begin
            @(negedge Clk);
            lat++;
            if (inject && lat == 2) begin
                key_code  = 5'd7;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
        end
    endtask

    // Submit, check score/latency, step past QREPORT and check game state.
    task automatic play(input string tag, input logic [24:0] w, input logic [24:0] t,
                        inout int exp_att, output bit done);
        int lat;
        logic [9:0] exp_r;
        exp_r = score(w, t);
        submit(w, 1'b0, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd6);
        chk({tag, "_result"}, 32'(result), 32'(exp_r));
        @(negedge Clk);
        exp_att++;
        chk({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
        chk({tag, "_attempt"}, 32'(attempt), 32'(exp_att));
        chk({tag, "_win"}, 32'(win), 32'(exp_r == 10'b1010101010));
        chk({tag, "_lose"}, 32'(lose), 32'(exp_r != 10'b1010101010 && exp_att == 6));
        done = (exp_r == 10'b1010101010) || exp_att == 6;
        chk({tag, "_state"}, 32'({q_Done, q_Entry}), done ? 32'd2 : 32'd1);
        if (!done) chk({tag, "_cleared"}, 32'({guess_len, guess_out}), 32'({3'd0, 25'h1FFFFFF}));
    endtask

    initial begin
        int att, lat;
        bit done;
        logic [24:0] crane, speed, eerie, t, g;
        crane = word(2, 17, 0, 13, 4);
        speed = word(18, 15, 4, 4, 3);
        eerie = word(4, 4, 17, 8, 4);
        reset = 1'b1; Start = 1'b0; Ack = 1'b0; key_valid = 1'b0; key_code = '0; target = '0;
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("rst_state", 32'({q_I, q_Entry, q_Green, q_Yellow, q_Report, q_Done}), 32'b100000);
        chk("rst_guess", 32'(guess_out), 32'h1FFFFFF);
        chk("rst_regs", 32'({guess_len, result, attempt, win, lose, result_valid}), 32'd0);

        // All-green win
        pulse_start(crane);
        chk("start_entry", 32'(q_Entry), 32'd1);
        att = 0;
        play("crane", crane, crane, att, done);
        chk("crane_const", 32'(result), 32'(10'b1010101010));
        press(5'd0);
        chk("done_ignores_key", 32'(guess_len), 32'd5);
        @(negedge Clk); Ack = 1'b1; @(negedge Clk); Ack = 1'b0;
        chk("ack_qi", 32'(q_I), 32'd1);
        chk("qi_hold", 32'({win, attempt}), 32'({1'b1, 3'd1}));

        // Duplicates; Start in QENTRY must not relatch target
        pulse_start(speed);
        pulse_start(crane);
        chk("start_in_entry", 32'(q_Entry), 32'd1);
        att = 0;
        submit(eerie, 1'b1, lat);
        chk("eerie_lat", 32'(lat), 32'd6);
        chk("eerie_const", 32'(result), 32'(10'b0000000101));
        chk("eerie_model", 32'(result), 32'(score(eerie, speed)));
        chk("yellow_key_ignored", 32'(guess_out), 32'(eerie));
        @(negedge Clk);
        chk("eerie_after", 32'({q_Entry, attempt, guess_out}), 32'({1'b1, 3'd1, 25'h1FFFFFF}));
        chk("result_held", 32'(result), 32'(10'b0000000101));
        att = 1;

        // Editing limits
        for (int i = 0; i < 6; i++) press(5'(i + 1));
        chk("six_len", 32'(guess_len), 32'd5);
        chk("six_buf", 32'(guess_out), 32'(word(1, 2, 3, 4, 5)));
        press(5'd26); press(5'd26);
        chk("del_len", 32'(guess_len), 32'd3);
        chk("del_buf", 32'(guess_out), 32'({10'h3FF, 15'(word(1, 2, 3, 0, 0))}));
        press(5'd27);
        repeat (2) @(negedge Clk);
        chk("short_enter", 32'({q_Entry, guess_len}), 32'({1'b1, 3'd3}));
        for (int i = 0; i < 4; i++) press(5'd26);
        press(5'd30);
        chk("empty", 32'({guess_len, guess_out}), 32'({3'd0, 25'h1FFFFFF}));

        // Finish this game with five losing guesses
        for (int k = 0; k < 5; k++) play("speedlose", word(k, 25, 24, 23, 22), speed, att, done);
        chk("lose_final", 32'({lose, win, attempt, q_Done}), 32'({1'b1, 1'b0, 3'd6, 1'b1}));
        @(negedge Clk); Ack = 1'b1; @(negedge Clk); Ack = 1'b0;

        // Randomized games over a small alphabet to force duplicate letters
        for (int gm = 0; gm < 6; gm++) begin
            t = word($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            pulse_start(t);
            att = 0;
            done = 0;
            for (int k = 0; k < 6 && !done; k++) begin
                g = word($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                if (k == 5 && gm == 0) g = t;
                play("rand", g, t, att, done);
            end
            @(negedge Clk); Ack = 1'b1; @(negedge Clk); Ack = 1'b0;
            chk("rand_qi", 32'(q_I), 32'd1);
        end

        // Reset during the third yellow cycle
        pulse_start(crane);
        for (int i = 0; i < 5; i++) press(5'(i + 2));
        press(5'd27);
        repeat (3) @(negedge Clk);
        chk("pre_reset_yellow", 32'(q_Yellow), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_reset_state", 32'(q_I), 32'd1);
        chk("mid_reset_regs", 32'({result, attempt, win, lose, guess_len}), 32'd0);
        chk("mid_reset_guess", 32'(guess_out), 32'h1FFFFFF);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wordle_guess_checker.md
# wordle_guess_checker

Consumer side of the on-screen Wordle keyboard. Receives the key codes the keyboard cursor emits and assembles a 5-letter guess with delete/enter editing. On enter, it scores the guess against a latched target word using exact Wordle rules, including duplicate letters. It tracks attempts up to a game limit and reports win or lose to the top-level game controller.

## Interface
- MAX_GUESSES, 6, number of guesses per game; legal range 1..7.

- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- Start  in  1  begin a game; latches target; honoured only in QI
- Ack  in  1  leave QDONE; honoured only in QDONE
- key_code  in  5  keyboard index: 0..25 = A..Z; 26 (',') = delete; 27 ('.') = enter; 28..31 ignored
- key_valid  in  1  one-cycle strobe qualifying key_code
- target  in  25  target word; position i at [5i+4:5i]
- guess_out  out  25  current guess buffer, same packing; empty slot = 5'h1F
- guess_len  out  3  letters entered, 0..5
- result  out  10  score for position i at [2i+1:2i]: 00 gray, 01 yellow, 10 green
- result_valid  out  1  high for exactly the QREPORT cycle
- attempt  out  3  completed guesses this game
- win, lose  out  1 each  game outcome; held through QDONE
- q_I, q_Entry, q_Green, q_Yellow, q_Report, q_Done  out  1 each  one-hot state

## Operation
- Reset and QI values: state QI; guess_out all 5'h1F; guess_len 0; result 0; attempt 0; win 0; lose 0; internal used flags 0; yellow index 0.
- QI: on Start, latch target, clear guess, attempt, win and lose, then go to QENTRY. Changes on target after the latch have no effect until the next Start.
- QENTRY: acts only on key_valid.
  - Letter code with guess_len < 5: store it in slot guess_len, then increment guess_len.
  - Code 26 with guess_len > 0: decrement guess_len and set the vacated slot to 5'h1F.
  - Code 27 with guess_len == 5: go to QGREEN.
  - Every other case, including codes 28..31, is ignored with no state change.
- QGREEN (1 cycle), for every position i in parallel:
  - guess[i] == tgt[i]: result[i] = 10 and used[i] = 1.
  - Otherwise: result[i] = 00 and used[i] = 0.
  - Next state QYELLOW with index 0.
- QYELLOW (5 cycles, index i = 0..4, one position per cycle):
  - If result[i] != 10, find the lowest j with used[j] == 0 and tgt[j] == guess[i].
  - If such a j exists, set result[i] = 01 and used[j] = 1.
  - After i = 4, go to QREPORT.
- QREPORT (1 cycle): result_valid = 1 and attempt increments. Then:
  - All five positions green: set win and go to QDONE.
  - Otherwise, if the new attempt == MAX_GUESSES: set lose and go to QDONE.
  - Otherwise: clear the guess (slots 5'h1F, len 0) and go to QENTRY.
- result holds its value until the next QGREEN, so it stays displayable during the next QENTRY.
- QDONE: on Ack go to QI; win, lose, attempt and result hold until then.
- key_valid is ignored in every state other than QENTRY.
- Start is ignored outside QI; Ack is ignored outside QDONE.
- Illegal state encodings go to QI.

## Timing
- All registers update on posedge Clk. reset acts immediately and asynchronously, at any point including mid-evaluation.
- Enter accepted at edge E0, then:
  - E1: green pass complete.
  - E2..E6: yellow positions 0..4.
  - QREPORT occupies the cycle between E6 and E7, with result_valid high and result stable.
  - E7: attempt incremented, next state taken.
- Enter-to-result_valid latency is 7 cycles. A key strobe after E7 in QENTRY is accepted.
- guess_out and guess_len update on the edge that samples key_valid.

## Test plan
- **All-green win.** Start with target CRANE {2,17,0,13,4}; key C,R,A,N,E then 27.
  - result_valid 7 cycles after enter, result = 10'b1010101010.
  - Then win = 1, attempt = 1, q_Done. Ack leads to q_I.
- **Duplicate scoring.** Target SPEED {18,15,4,4,3}; guess EERIE {4,4,17,8,4}.
  - result = 10'b0000000101 (positions 0 and 1 yellow, position 4 gray).
  - Then QENTRY with guess_out all 5'h1F and attempt = 1.
- **Editing limits.** Enter 6 letters: guess_len stays 5 and the 6th is dropped.
  - Two deletes: guess_len = 3, slots 3 and 4 = 5'h1F.
  - Enter at len 3 is ignored; state stays QENTRY.
  - Delete at len 0 is ignored. Code 30 is ignored.
- **Lose.** MAX_GUESSES = 6 with six wrong guesses.
  - lose = 1 and attempt = 6 after the 6th QREPORT; win = 0; q_Done.
- **Reset mid-op.** Assert reset during the 3rd QYELLOW cycle.
  - Immediately q_I, result 0, attempt 0, guess all 5'h1F, win = lose = 0.
- **Ignored inputs.** key_valid strobes with letter codes during QYELLOW leave guess_out unchanged. Start during QENTRY does not relatch target.
